dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port round-robin arbiter that shares the single-port 8-bit data memory between two requesters: port 0 is the CPU load/store stage and port 1 is the debug/DMA loader. It serializes accesses, drives the memory's address, write-data and write-enable inputs, and routes registered read data back to the winning port. It sits between the requesters and the data memory, which is the arbiter's only memory-side peer.

## Interface
- ADDR_W, 8, address width, matching the 256-entry memory
- DATA_W, 8, data width
- sysclk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request; held high until the matching gnt is seen
- we0 / we1  in  1  1 = write, 0 = read; valid while req is high
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted; requester may change req/we/addr/wdata from the next edge
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata holds read result for that port
- rdata  out  DATA_W  read data, shared by both ports, qualified by rvalid0/1
- busy  out  1  high in any state other than IDLE
- mem_addr  out  ADDR_W  to memory addr
- mem_writeData  out  DATA_W  to memory writeData
- mem_write  out  1  to memory write
- mem_readData  in  DATA_W  from memory readData; valid one cycle after the memory samples a read

## Operation
- FSM states: IDLE, MEM, RDWAIT.
- IDLE:
  - Requests are sampled only in IDLE.
  - With any req high: pick the winner, register the command into mem_addr, mem_writeData and mem_write (mem_write = we of the winner), pulse gnt of the winner, and go to MEM.
- MEM: the command is presented to memory.
  - Write: the memory commits it at the closing edge; go to IDLE.
  - Read: go to RDWAIT.
  - mem_write clears to 0 at the closing edge.
- RDWAIT: capture mem_readData into rdata, pulse rvalid of the owner, go to IDLE.
- Round-robin:
  - A 1-bit prio register names the preferred port; reset value 0.
  - Both req high: prio wins.
  - One req high: that port wins.
  - After every grant, prio is set to the non-winning port.
- mem_write is 1 only during MEM for a write. It is never 1 in IDLE or RDWAIT, so no spurious stores occur.
- mem_addr and mem_writeData hold their last value when not in MEM.
- Reset values: state IDLE, prio 0, gnt0/1 0, rvalid0/1 0, rdata 0, busy 0, mem_addr 0, mem_writeData 0, mem_write 0.

## Timing
- Req sampled at edge E0.
  - gnt and busy are high in the E0–E1 cycle, and mem_* carry the command then.
  - The memory samples at E1.
- Write: stored at E1. The earliest next grant is sampled at E2, giving a throughput of 1 write per 2 cycles.
- Read: memory data is valid after E1 and captured at E2. rvalid and rdata are valid in the E2–E3 cycle, so rvalid comes 2 cycles after gnt. The earliest next grant is sampled at E3.
- A requester that keeps req high after gnt is treated as a new request at the next IDLE sample. Back-to-back accesses therefore need no idle cycle on the requester side.
- Simultaneous req0 and req1 in IDLE: alternation is strict. Under continuous contention, grants go 0, 1, 0, 1 starting from the current prio.
- Reset mid-operation:
  - Reset sampled at E1 while in MEM-write: the write still commits at E1, because the command was already presented. All outputs return to reset values after E1.
  - Reset in MEM-read or RDWAIT: the read is dropped and no rvalid is issued.
- Req asserted while busy: ignored until IDLE. It is not lost if the requester holds it.

## Structure
- Package dmem_arb_pkg holds:
  - the state type (IDLE, MEM, RDWAIT)
  - ADDR_W/DATA_W defaults
  - port index constants (PORT_CPU = 0, PORT_DBG = 1)
- Sub-module rr_pick2 is combinational. It takes req0, req1 and prio, and outputs winner and any_req. It is reusable for other two-way shared resources.
- The top holds the FSM, the prio and owner registers, the memory command registers and the rdata capture.

## Test plan
- Reset: hold reset 2 cycles → every output 0, busy 0, no mem_write pulse during or after reset.
- Single write/read:
  - req0 writes 0xA5 to address 0x10 → gnt0 pulse at E0+1, mem_write high exactly 1 cycle.
  - Then req0 reads 0x10 → rvalid0 2 cycles after gnt0, with rdata = 0xA5.
- Contention: req0 and req1 both held with reads of addresses 0x01 and 0x02 preloaded with 0x11 and 0x22 → grant order 0, 1, 0, 1, with rdata 0x11 on rvalid0 and 0x22 on rvalid1. rvalid1 never pulses for a port-0 access.
- Priority rotation: req1 alone, then both asserted → port 0 wins, because prio moved to 0 after the port-1 grant.
- Reset mid-access:
  - Reset at E1 of a write of 0x3C to address 0x20 → the memory holds 0x3C.
  - Reset during RDWAIT → no rvalid, state IDLE, prio 0.
- Back-to-back writes from port 1 with req held continuously → one gnt1 every 2 cycles, and all writes land in order.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_RDWAIT
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the arbiter: two request ports plus shared read data and busy.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: prio breaks ties, a lone request always wins.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic winner,
  output logic any_req
);

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      winner = prio;
    end else if (req1) begin
      winner = PORT_DBG;
    end else begin
      winner = PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter serializing two requesters onto the single-port data memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
)(
  input  logic              sysclk,
  input  logic              reset,
  dmem_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_readData
);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              winner;
  logic              any_req;

  rr_pick2 u_pick (
    .req0    (bus.req0),
    .req1    (bus.req1),
    .prio    (prio_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;
    rdata_d     = rdata_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d     = ST_MEM;
          owner_d     = winner;
          prio_d      = ~winner;
          mem_addr_d  = (winner == PORT_DBG) ? bus.addr1  : bus.addr0;
          mem_wdata_d = (winner == PORT_DBG) ? bus.wdata1 : bus.wdata0;
          mem_write_d = (winner == PORT_DBG) ? bus.we1    : bus.we0;
          gnt0_d      = (winner == PORT_CPU);
          gnt1_d      = (winner == PORT_DBG);
        end
      end
      // The memory samples the command at the closing edge of this state.
      ST_MEM: begin
        state_d = mem_write_q ? ST_IDLE : ST_RDWAIT;
      end
      ST_RDWAIT: begin
        rdata_d   = mem_readData;
        rvalid0_d = (owner_q == PORT_CPU);
        rvalid1_d = (owner_q == PORT_DBG);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prio_q      <= PORT_CPU;
      owner_q     <= PORT_CPU;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      rdata_q     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      rdata_q     <= rdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign mem_addr      = mem_addr_q;
  assign mem_writeData = mem_wdata_q;
  assign mem_write     = mem_write_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic sysclk = 1'b0;
  logic reset;
  always #5 sysclk = ~sysclk;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  logic [7:0] mem_addr;
  logic [7:0] mem_writeData;
  logic [7:0] mem_readData;
  logic       mem_write;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .bus           (bus),
    .mem_addr      (mem_addr),
    .mem_writeData (mem_writeData),
    .mem_write     (mem_write),
    .mem_readData  (mem_readData)
  );

  // Single-port memory peer with one-cycle registered read.
  logic [7:0] mem [256];
  always @(posedge sysclk) begin
    if (mem_write) mem[mem_addr] <= mem_writeData;
    mem_readData <= mem[mem_addr];
  end

  logic       req_v   [2];
  logic       we_v    [2];
  logic [7:0] addr_v  [2];
  logic [7:0] wdata_v [2];
  assign bus.req0   = req_v[0];
  assign bus.req1   = req_v[1];
  assign bus.we0    = we_v[0];
  assign bus.we1    = we_v[1];
  assign bus.addr0  = addr_v[0];
  assign bus.addr1  = addr_v[1];
  assign bus.wdata0 = wdata_v[0];
  assign bus.wdata1 = wdata_v[1];

  logic [7:0]  ref_mem [256];
  bit          written [256];
  bit          pending [2];
  bit          prio_m;
  int unsigned cyc;
  int unsigned gnt_cyc;
  int          checks;
  int          errors;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_gnt0"}, bus.gnt0, 0);
    chk({tag, "_gnt1"}, bus.gnt1, 0);
    chk({tag, "_rvalid0"}, bus.rvalid0, 0);
    chk({tag, "_rvalid1"}, bus.rvalid1, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_writeData, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
  endtask

  task automatic post(input int unsigned p, input logic w, input logic [7:0] a, input logic [7:0] d);
    req_v[p]   = 1'b1;
    we_v[p]    = w;
    addr_v[p]  = a;
    wdata_v[p] = d;
    pending[p] = 1'b1;
  endtask

  function automatic int unsigned exp_winner();
    if (pending[0] && pending[1]) return int'(prio_m);
    return pending[1] ? 1 : 0;
  endfunction

  // Expects the arbiter idle with port p's request winning at the next edge.
  task automatic serve(input int unsigned p, input bit hold);
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    w = we_v[p];
    a = addr_v[p];
    d = wdata_v[p];
    tick();
    chk("e0_gnt0", bus.gnt0, p == 0);
    chk("e0_gnt1", bus.gnt1, p == 1);
    chk("e0_busy", bus.busy, 1);
    chk("e0_mem_addr", mem_addr, a);
    chk("e0_mem_write", mem_write, w);
    if (w) chk("e0_mem_wdata", mem_writeData, d);
    chk("e0_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
    gnt_cyc    = cyc;
    prio_m     = (p == 0);
    pending[p] = 1'b0;
    if (!hold) req_v[p] = 1'b0;
    tick();
    chk("e1_gnt", {bus.gnt1, bus.gnt0}, 0);
    chk("e1_mem_write", mem_write, 0);
    chk("e1_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
    if (w) begin
      ref_mem[a] = d;
      written[a] = 1'b1;
      chk("e1_busy_wr", bus.busy, 0);
    end else begin
      chk("e1_busy_rd", bus.busy, 1);
      tick();
      chk("e2_rvalid0", bus.rvalid0, p == 0);
      chk("e2_rvalid1", bus.rvalid1, p == 1);
      chk("e2_rdata", bus.rdata, ref_mem[a]);
      chk("e2_busy", bus.busy, 0);
      chk("e2_mem_write", mem_write, 0);
    end
  endtask

  initial begin
    logic [7:0]  ra;
    logic        rw;
    int unsigned prev;
    checks = 0;
    errors = 0;
    prio_m = 1'b0;
    for (int unsigned p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wdata_v[p] = '0; pending[p] = 1'b0;
    end

    reset = 1'b1;
    tick(); chk_rst("rst_a");
    tick(); chk_rst("rst_b");
    reset = 1'b0;
    tick(); chk_rst("rst_idle");

    post(0, 1'b1, 8'h10, 8'hA5); serve(0, 1'b0);
    chk("wr_mem_a5", mem[8'h10], 8'hA5);
    post(0, 1'b0, 8'h10, 8'h00); serve(0, 1'b0);
    chk("rd_rdata_a5", bus.rdata, 8'hA5);

    post(0, 1'b1, 8'h01, 8'h11); serve(0, 1'b0);
    post(1, 1'b1, 8'h02, 8'h22); serve(1, 1'b0);

    // Both ports hold read requests continuously: strict alternation.
    post(0, 1'b0, 8'h01, 8'h00);
    post(1, 1'b0, 8'h02, 8'h00);
    serve(0, 1'b1); chk("cont_r0", bus.rdata, 8'h11); post(0, 1'b0, 8'h01, 8'h00);
    serve(1, 1'b1); chk("cont_r1", bus.rdata, 8'h22); post(1, 1'b0, 8'h02, 8'h00);
    serve(0, 1'b1); chk("cont_r2", bus.rdata, 8'h11);
    serve(1, 1'b0); chk("cont_r3", bus.rdata, 8'h22);
    req_v[0] = 1'b0;

    post(1, 1'b1, 8'h30, 8'h77); serve(1, 1'b0);
    post(0, 1'b0, 8'h01, 8'h00);
    post(1, 1'b0, 8'h30, 8'h00);
    serve(0, 1'b0);
    serve(1, 1'b0);
    chk("rot_rdata", bus.rdata, 8'h77);

    // Reset sampled at E1 of a write: the presented write still lands.
    post(0, 1'b1, 8'h20, 8'h3C);
    tick();
    chk("rstw_gnt0", bus.gnt0, 1);
    chk("rstw_mem_write", mem_write, 1);
    req_v[0] = 1'b0; pending[0] = 1'b0;
    reset = 1'b1;
    tick(); chk_rst("rstw");
    reset = 1'b0; prio_m = 1'b0;
    chk("rstw_mem", mem[8'h20], 8'h3C);
    ref_mem[8'h20] = 8'h3C; written[8'h20] = 1'b1;

    // Reset during RDWAIT: read dropped, prio back to port 0.
    post(0, 1'b0, 8'h10, 8'h00);
    tick();
    chk("rstr_gnt0", bus.gnt0, 1);
    req_v[0] = 1'b0; pending[0] = 1'b0;
    tick();
    chk("rstr_busy", bus.busy, 1);
    reset = 1'b1;
    tick(); chk_rst("rstr");
    reset = 1'b0; prio_m = 1'b0;
    tick();
    chk("rstr_no_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
    chk("rstr_idle", bus.busy, 0);
    post(0, 1'b0, 8'h20, 8'h00);
    post(1, 1'b0, 8'h02, 8'h00);
    serve(0, 1'b0); chk("rstr_after0", bus.rdata, 8'h3C);
    serve(1, 1'b0); chk("rstr_after1", bus.rdata, 8'h22);

    post(1, 1'b1, 8'h50, 8'h90);
    prev = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      serve(1, k < 3);
      if (k > 0) chk("b2b_gap", gnt_cyc - prev, 2);
      prev = gnt_cyc;
      if (k < 3) post(1, 1'b1, 8'h51 + 8'(k), 8'h91 + 8'(k));
    end
    for (int unsigned k = 0; k < 4; k++) chk("b2b_mem", mem[8'h50 + 8'(k)], 8'h90 + 8'(k));

    for (int unsigned n = 0; n < 200; n++) begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (!pending[p] && $urandom_range(1, 0) == 1) begin
          ra = 8'h40 + 8'($urandom_range(15, 0));
          rw = !written[ra] || ($urandom_range(1, 0) == 1);
          post(p, rw, ra, 8'($urandom));
        end
      end
      if (!pending[0] && !pending[1]) begin
        tick();
        chk("rnd_idle_gnt", {bus.gnt1, bus.gnt0}, 0);
        chk("rnd_idle_busy", bus.busy, 0);
        chk("rnd_idle_mem_write", mem_write, 0);
      end else begin
        serve(exp_winner(), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
